// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl
// Write-side controller for the register file write port. ALU results and
// variable-latency load returns share one registered write port. ALU results
// win arbitration. Loads that cannot be written straight away wait in a small
// in-order queue. A per-register pending scoreboard tells decode which
// registers are still waiting on an issued load. The in-flight write is
// forwarded to decode, because the file itself only updates at the next edge.
//
// Load-return handshake: a load transfer happens on a rising edge where
// ld_valid & ld_ready are both 1. ld_ready depends only on registered state,
// and on reset, and never on ld_valid. Upstream holds ld_rd and ld_data stable
// while ld_valid=1 and the transfer has not yet happened.

module rf_writeback_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  // ALU result, always accepted
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  // load return
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  // load issue, for the scoreboard
  input  logic              iss_ld_valid,
  input  logic [ADDR_W-1:0] iss_ld_rd,
  // register file write port
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  // decode read side
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rs1_fwd,
  output logic              rs2_fwd,
  output logic [DATA_W-1:0] rs1_fdata,
  output logic [DATA_W-1:0] rs2_fdata
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int NREG  = 2 ** ADDR_W;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(LQ_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_q_rd   [LQ_DEPTH];
  logic [DATA_W-1:0] r_q_data [LQ_DEPTH];
  logic [NREG-1:0]   r_pending;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  // ---------------------------------------------------------------------------
  // Arbitration and queue control
  // ---------------------------------------------------------------------------
  logic              w_ld_acc;
  logic              w_ld_nz;
  logic              w_sel_alu;
  logic              w_q_nonempty;
  logic              w_sel_q;
  logic              w_sel_dir;
  logic              w_push;
  logic              w_pop;
  logic              w_ld_wr;
  logic [ADDR_W-1:0] w_clr_rd;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_waddr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic [PTR_W:0]    w_count_nxt;
  logic [NREG-1:0]   w_pending_nxt;

  // Ready comes from the registered count only. A pop in the same cycle
  // does not raise it. It is held low while reset is asserted.
  assign ld_ready = ~reset & (r_count < DEPTH_C);

  // Priority order: ALU first, then the queue head, then a direct load. A load
  // is written directly only when the queue is empty, so loads stay in order.
  always_comb begin
    w_ld_acc     = ld_valid & ld_ready;
    w_ld_nz      = (ld_rd != '0);
    w_sel_alu    = alu_valid & (alu_rd != '0);
    w_q_nonempty = (r_count != '0);
    w_sel_q      = ~w_sel_alu & w_q_nonempty;
    w_sel_dir    = ~w_sel_alu & ~w_q_nonempty & w_ld_acc & w_ld_nz;
    // An accepted load to x0 is dropped here. It is never queued.
    w_push       = w_ld_acc & w_ld_nz & ~w_sel_dir;
    w_pop        = w_sel_q;
    w_ld_wr      = w_sel_q | w_sel_dir;
    w_clr_rd     = w_sel_q ? r_q_rd[r_head] : ld_rd;
  end

  // Next write-port contents. Address and data hold when nothing is selected.
  always_comb begin
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    if (w_sel_alu) begin
      w_we_nxt    = 1'b1;
      w_waddr_nxt = alu_rd;
      w_wdata_nxt = alu_data;
    end else if (w_sel_q) begin
      w_we_nxt    = 1'b1;
      w_waddr_nxt = r_q_rd[r_head];
      w_wdata_nxt = r_q_data[r_head];
    end else if (w_sel_dir) begin
      w_we_nxt    = 1'b1;
      w_waddr_nxt = ld_rd;
      w_wdata_nxt = ld_data;
    end
  end

  // Queue occupancy. A push and a pop in the same cycle leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (PTR_W + 1)'(1);
      2'b01:   w_count_nxt = r_count - (PTR_W + 1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Scoreboard update. The clear is applied first, so a same-cycle set wins.
  // Bit 0 is forced low because x0 never waits on a load.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_ld_wr) begin
      w_pending_nxt[w_clr_rd] = 1'b0;
    end
    if (iss_ld_valid && (iss_ld_rd != '0)) begin
      w_pending_nxt[iss_ld_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Sequential
  // ---------------------------------------------------------------------------

  // Queue pointers and count. On reset these are cleared, which discards
  // every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Queue payload storage. It needs no reset, because the pointers alone
  // decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_tail]   <= ld_rd;
      r_q_data[r_tail] <= ld_data;
    end
  end

  // Pending-load scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Registered write port. This gives one cycle of latency from selection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we    <= w_we_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

  // ---------------------------------------------------------------------------
  // Decode-side busy and forwarding
  // ---------------------------------------------------------------------------
  logic w_rs1_nz;
  logic w_rs2_nz;

  // Busy and forward flags. The register file has not yet absorbed the
  // in-flight write, so decode takes that value from here.
  always_comb begin
    w_rs1_nz  = (rs1 != '0);
    w_rs2_nz  = (rs2 != '0);
    rs1_busy  = r_pending[rs1] & w_rs1_nz;
    rs2_busy  = r_pending[rs2] & w_rs2_nz;
    rs1_fwd   = r_we & (r_waddr == rs1) & w_rs1_nz;
    rs2_fwd   = r_we & (r_waddr == rs2) & w_rs2_nz;
    rs1_fdata = rs1_fwd ? r_wdata : '0;
    rs2_fdata = rs2_fwd ? r_wdata : '0;
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Testbench for rf_writeback_ctrl. Expected register-file writes are queued
// as stimulus is driven. A negedge monitor pops and compares each rf_we cycle.
module tb_rf_writeback_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int EW     = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              alu_valid = 1'b0;
  logic [ADDR_W-1:0] alu_rd = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              iss_ld_valid = 1'b0;
  logic [ADDR_W-1:0] iss_ld_rd = '0;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rs1 = '0;
  logic [ADDR_W-1:0] rs2 = '0;
  logic              rs1_busy, rs2_busy, rs1_fwd, rs2_fwd;
  logic [DATA_W-1:0] rs1_fdata, rs2_fdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;

  rf_writeback_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_ld_valid(iss_ld_valid), .iss_ld_rd(iss_ld_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .rs1_fdata(rs1_fdata), .rs2_fdata(rs2_fdata)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset && rf_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL write_unexpected: got addr=%0d data=%08h, required no write",
                 rf_waddr, rf_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== mon_exp) begin
          n_errors++;
          $display("FAIL write_order: got addr=%0d data=%08h, required addr=%0d data=%08h",
                   rf_waddr, rf_wdata, mon_exp[EW-1 -: ADDR_W], mon_exp[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %08h, required %08h", name, got, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1;
    chk("reset_we",    32'(rf_we), 32'd0);
    chk("reset_waddr", 32'(rf_waddr), 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_ready", 32'(ld_ready), 32'd1);
    rs1 = 5'd9;
    rs2 = 5'd1;
    #1;
    chk("reset_busy", 32'({rs1_busy, rs2_busy}), 32'd0);
  endtask

  task automatic test_alu_fwd();
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEAD_BEEF;
    exp_q.push_back({alu_rd, alu_data});
    tick();
    alu_valid = 1'b0;
    rs1 = 5'd5;
    rs2 = 5'd6;
    #1;
    chk("alu_we",     32'(rf_we), 32'd1);
    chk("alu_waddr",  32'(rf_waddr), 32'd5);
    chk("alu_wdata",  rf_wdata, 32'hDEAD_BEEF);
    chk("alu_fwd1",   32'(rs1_fwd), 32'd1);
    chk("alu_fdata1", rs1_fdata, 32'hDEAD_BEEF);
    chk("alu_fwd2",   32'(rs2_fwd), 32'd0);
    chk("alu_fdata2", rs2_fdata, 32'd0);
    tick();
    chk("alu_fwd_gone", 32'(rs1_fwd), 32'd0);
  endtask

  task automatic test_load_scoreboard();
    iss_ld_valid = 1'b1;
    iss_ld_rd    = 5'd7;
    tick();
    iss_ld_valid = 1'b0;
    rs1 = 5'd7;
    tick();
    chk("ld_busy_set", 32'(rs1_busy), 32'd1);
    ld_valid = 1'b1;
    ld_rd    = 5'd7;
    ld_data  = 32'h0000_1234;
    chk("ld_busy_before_wr", 32'(rs1_busy), 32'd1);
    chk("ld_ready_idle", 32'(ld_ready), 32'd1);
    exp_q.push_back({ld_rd, ld_data});
    tick();
    ld_valid = 1'b0;
    chk("ld_direct_we",    32'(rf_we), 32'd1);
    chk("ld_direct_waddr", 32'(rf_waddr), 32'd7);
    chk("ld_direct_wdata", rf_wdata, 32'h0000_1234);
    chk("ld_busy_clear",   32'(rs1_busy), 32'd0);
    // A load write and a new issue to the same register in one cycle: set wins.
    ld_valid     = 1'b1;
    ld_data      = 32'h0000_5678;
    iss_ld_valid = 1'b1;
    exp_q.push_back({ld_rd, ld_data});
    tick();
    ld_valid     = 1'b0;
    iss_ld_valid = 1'b0;
    chk("set_wins_busy", 32'(rs1_busy), 32'd1);
    ld_valid = 1'b1;
    ld_data  = 32'h0000_9ABC;
    exp_q.push_back({ld_rd, ld_data});
    tick();
    ld_valid = 1'b0;
    chk("second_clear_busy", 32'(rs1_busy), 32'd0);
    tick();
  endtask

  task automatic test_alu_and_load();
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_data  = 32'h3333_0003;
    ld_valid  = 1'b1;
    ld_rd     = 5'd4;
    ld_data   = 32'h4444_0004;
    exp_q.push_back({alu_rd, alu_data});
    exp_q.push_back({ld_rd, ld_data});
    tick();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    chk("same_cyc_alu_addr", 32'(rf_waddr), 32'd3);
    tick();
    chk("same_cyc_ld_we",   32'(rf_we), 32'd1);
    chk("same_cyc_ld_addr", 32'(rf_waddr), 32'd4);
    tick();
    chk("same_cyc_idle", 32'(rf_we), 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] ld_list[$];
    int li = 0;
    int bound;
    alu_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      alu_rd   = ADDR_W'(20 + c);
      alu_data = $urandom;
      exp_q.push_back({alu_rd, alu_data});
      if (li < 5) begin
        ld_valid = 1'b1;
        ld_rd    = ADDR_W'(8 + li);
        ld_data  = 32'hA000_0000 | 32'(8 + li);
      end else begin
        ld_valid = 1'b0;
      end
      if (c == 6) begin
        chk("b2b_ready_full", 32'(ld_ready), 32'd0);
        chk("b2b_accepted",   32'(li), 32'd4);
      end
      if (ld_valid && ld_ready) begin
        ld_list.push_back({ld_rd, ld_data});
        li++;
      end
      tick();
    end
    alu_valid = 1'b0;
    foreach (ld_list[i]) exp_q.push_back(ld_list[i]);
    chk("b2b_ready_no_pop_raise", 32'(ld_ready), 32'd0);
    tick();
    chk("b2b_ready_after_pop", 32'(ld_ready), 32'd1);
    if (ld_valid && ld_ready) exp_q.push_back({ld_rd, ld_data});
    tick();
    ld_valid = 1'b0;
    bound = 0;
    while (exp_q.size() != 0 && bound < 30) begin
      tick();
      bound++;
    end
    chk("b2b_drain", 32'(exp_q.size()), 32'd0);
    chk("b2b_ready_final", 32'(ld_ready), 32'd1);
  endtask

  task automatic test_x0();
    alu_valid    = 1'b1;
    alu_rd       = 5'd0;
    alu_data     = 32'hFFFF_0000;
    ld_valid     = 1'b1;
    ld_rd        = 5'd0;
    ld_data      = 32'h0F0F_0F0F;
    iss_ld_valid = 1'b1;
    iss_ld_rd    = 5'd0;
    rs1          = 5'd0;
    #1;
    chk("x0_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    alu_valid    = 1'b0;
    ld_valid     = 1'b0;
    iss_ld_valid = 1'b0;
    chk("x0_no_we", 32'(rf_we), 32'd0);
    chk("x0_busy",  32'(rs1_busy), 32'd0);
    chk("x0_fwd",   32'(rs1_fwd), 32'd0);
    tick();
    chk("x0_no_queue_we", 32'(rf_we), 32'd0);
  endtask

  task automatic test_reset_midflight();
    iss_ld_valid = 1'b1;
    iss_ld_rd    = 5'd9;
    tick();
    iss_ld_valid = 1'b0;
    alu_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      alu_rd   = ADDR_W'(24 + c);
      alu_data = $urandom;
      exp_q.push_back({alu_rd, alu_data});
      ld_valid = 1'b1;
      ld_rd    = ADDR_W'(13 + c);
      ld_data  = 32'hB000_0000 | 32'(c);
      tick();
    end
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    rs1 = 5'd9;
    #1;
    chk("rst_pre_busy", 32'(rs1_busy), 32'd1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("rst_async_we",    32'(rf_we), 32'd0);
    chk("rst_async_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_async_busy",  32'(rs1_busy), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    ld_valid = 1'b1;
    ld_rd    = 5'd16;
    ld_data  = 32'h0000_0016;
    exp_q.push_back({ld_rd, ld_data});
    tick();
    ld_valid = 1'b0;
    chk("rst_queue_empty_direct", 32'(rf_waddr), 32'd16);
    chk("rst_queue_empty_we",     32'(rf_we), 32'd1);
    tick();
  endtask

  initial begin
    test_reset();
    tick();
    test_alu_fwd();
    test_load_scoreboard();
    test_alu_and_load();
    test_back_to_back();
    test_x0();
    test_reset_midflight();
    tick();
    tick();
    chk("final_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
